prbs_wide_check: RTL and testbench

Parallel, self-synchronising PRBS checker for the BER tester receive path. It consumes DATA_WIDTH bits per accepted word and acquires lock to a PRBS7/15/23/31 stream with a run-time selectable polynomial. Once locked, it counts bit errors and checked bits in saturating counters. It is the receive-side counterpart of the wide PRBS generator.

---
 rtl/prbs_pkg.sv | 11 +
 rtl/prbs_wide_predict.sv | 26 ++
 rtl/prbs_wide_check.sv | 110 +++++++++++
 tb/tb_prbs_wide_check.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: PRBS polynomial selection and checker state types shared by the generator and checker
package prbs_pkg;
  typedef enum logic [1:0] {PRBS7, PRBS15, PRBS23, PRBS31} prbs_mode_e;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_e;
  localparam int PRBS_HIST_W = 31;
  function automatic logic [9:0] prbs_taps(input prbs_mode_e mode);
    return mode == PRBS7  ? {5'd7, 5'd6} :
           mode == PRBS15 ? {5'd15, 5'd14} :
           mode == PRBS23 ? {5'd23, 5'd18} : {5'd31, 5'd28};
  endfunction
endpackage

// File: rtl/prbs_wide_predict.sv
// prbs_wide_predict: expected next DATA_WIDTH bits (MSB first) and the history after them
import prbs_pkg::*;
module prbs_wide_predict #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [PRBS_HIST_W-1:0] history,
  input  logic [1:0]             mode,
  output logic [DATA_WIDTH-1:0]  expected,
  output logic [PRBS_HIST_W-1:0] next_history
);
  logic [4:0] n, m;
  always_comb begin
    logic [PRBS_HIST_W-1:0] h;
    logic b;
    {n, m} = prbs_taps(prbs_mode_e'(mode));
    h = history;
    b = 1'b0;
    expected = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      b = h[n - 5'd1] ^ h[m - 5'd1];
      expected[i] = b;
      h = {h[PRBS_HIST_W-2:0], b};
    end
    next_history = h;
  end
endmodule

// File: rtl/prbs_wide_check.sv
// prbs_wide_check: self-synchronising parallel PRBS checker with lock tracking and saturating BER counters
import prbs_pkg::*;
module prbs_wide_check #(
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4,
  parameter int LOSS_BITS  = DATA_WIDTH / 4,
  parameter int ERR_W      = 32,
  parameter int BIT_W      = 48
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      mode,
  input  logic                            data_valid,
  input  logic [DATA_WIDTH-1:0]           data,
  input  logic                            clear,
  output logic                            locked,
  output logic                            word_err_valid,
  output logic [$clog2(DATA_WIDTH+1)-1:0] word_err,
  output logic [ERR_W-1:0]                err_count,
  output logic [BIT_W-1:0]                bit_count,
  output logic                            err_sat
);
  localparam int WE  = $clog2(DATA_WIDTH + 1);
  localparam int GCW = $clog2(LOCK_COUNT + 1);
  localparam int BCW = $clog2(LOSS_COUNT + 1);
  localparam int SW  = (ERR_W > WE ? ERR_W : WE) + 1;
  chk_state_e state, state_d;
  logic [1:0] mode_q;
  logic [PRBS_HIST_W-1:0] hist, hist_d, hist_nx;
  logic [DATA_WIDTH-1:0] expected;
  logic [GCW-1:0] good, good_d;
  logic [BCW-1:0] bad, bad_d;
  logic [WE-1:0] pop;
  logic mode_chg, hit, count;
  logic [SW-1:0] err_sum;
  logic [BIT_W:0] bit_sum;
  logic [ERR_W-1:0] err_n;
  logic [BIT_W-1:0] bit_n;
  prbs_wide_predict #(.DATA_WIDTH(DATA_WIDTH)) u_pred (
    .history(hist), .mode(mode), .expected(expected), .next_history(hist_nx)
  );
  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pop += WE'(data[i] ^ expected[i]);
  end
  assign mode_chg = mode != mode_q;
  assign hit      = data == expected;
  assign count    = data_valid && !mode_chg && state == LOCKED;
  assign locked   = state == LOCKED;
  // A mode change forces a re-hunt; a word arriving with it seeds under the new polynomial
  always_comb begin
    state_d = state;
    hist_d  = hist;
    good_d  = good;
    bad_d   = bad;
    if (mode_chg) begin
      state_d = HUNT;
      good_d  = '0;
      bad_d   = '0;
    end
    if (data_valid) begin
      if (mode_chg || state == HUNT) begin
        state_d = VERIFY;
        hist_d  = data[PRBS_HIST_W-1:0];
        good_d  = '0;
      end else if (state == VERIFY) begin
        hist_d = hit ? hist_nx : data[PRBS_HIST_W-1:0];
        good_d = hit ? good + 1'b1 : '0;
        if (good_d == GCW'(LOCK_COUNT)) begin
          state_d = LOCKED;
          bad_d   = '0;
        end
      end else begin
        hist_d = hist_nx;
        bad_d  = pop > WE'(LOSS_BITS) ? bad + 1'b1 : '0;
        if (bad_d == BCW'(LOSS_COUNT)) state_d = HUNT;
      end
    end
  end
  // Counters clamp at all-ones once any carry leaves their width
  assign err_sum = SW'(err_count) + SW'(pop);
  assign bit_sum = {1'b0, bit_count} + (BIT_W + 1)'(DATA_WIDTH);
  assign err_n   = !count ? err_count : |err_sum[SW-1:ERR_W] ? '1 : err_sum[ERR_W-1:0];
  assign bit_n   = !count ? bit_count : bit_sum[BIT_W] ? '1 : bit_sum[BIT_W-1:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state          <= HUNT;
      mode_q         <= '0;
      hist           <= '0;
      good           <= '0;
      bad            <= '0;
      word_err_valid <= 1'b0;
      word_err       <= '0;
      err_count      <= '0;
      bit_count      <= '0;
      err_sat        <= 1'b0;
    end else begin
      state          <= state_d;
      mode_q         <= mode;
      hist           <= hist_d;
      good           <= good_d;
      bad            <= bad_d;
      word_err_valid <= count;
      word_err       <= count ? pop : '0;
      err_count      <= clear ? '0 : err_n;
      bit_count      <= clear ? '0 : bit_n;
      err_sat        <= !clear && (err_sat || &err_n || &bit_n);
    end
endmodule

// File: tb/tb_prbs_wide_check.sv
// tb_prbs_wide_check: directed scenarios with random PRBS seeds and error patterns, checked against a bit-queue model
module tb_prbs_wide_check;
  localparam int W = 32, EW = 8, BW = 12;
  localparam int EMAX = 255, BMAX = 4095;
  typedef bit bq_t[$];
  logic clk = 0, reset = 0, data_valid = 0, clear = 0;
  logic [1:0] mode = 0;
  logic [W-1:0] data = 0;
  logic locked, word_err_valid, err_sat;
  logic [5:0] word_err;
  logic [EW-1:0] err_count;
  logic [BW-1:0] bit_count;
  int checks = 0, passed = 0;
  int m_state, m_good, m_bad, m_mq, m_we, m_ec, m_bc;
  bit m_wev, m_sat;
  bq_t m_hist, gq;
  int gmode;

  always #5 clk = ~clk;

  prbs_wide_check #(.DATA_WIDTH(W), .ERR_W(EW), .BIT_W(BW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .data_valid(data_valid), .data(data), .clear(clear),
    .locked(locked), .word_err_valid(word_err_valid), .word_err(word_err),
    .err_count(err_count), .bit_count(bit_count), .err_sat(err_sat)
  );

  function automatic int tap_n(int md);
    return md == 0 ? 7 : md == 1 ? 15 : md == 2 ? 23 : 31;
  endfunction
  function automatic int tap_m(int md);
    return md == 0 ? 6 : md == 1 ? 14 : md == 2 ? 18 : 28;
  endfunction
  // Extend the bit sequence by W bits with s[n] = s[n-N] ^ s[n-M]; earliest bit lands at the MSB
  function automatic logic [W-1:0] predict(bq_t q, int md);
    bq_t s = q;
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) begin
      s.push_back(s[s.size() - tap_n(md)] ^ s[s.size() - tap_m(md)]);
      w[W-1-i] = s[s.size() - 1];
    end
    return w;
  endfunction
  function automatic bq_t adv(bq_t q, logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
    while (q.size() > 31) void'(q.pop_front());
    return q;
  endfunction

  task automatic gen_seed(int md);
    gmode = md;
    gq.delete();
    for (int i = 0; i < 31; i++) gq.push_back(bit'($urandom_range(0, 1)));
    gq[30] = 1'b1;
  endtask
  task automatic gen(output logic [W-1:0] w);
    w = predict(gq, gmode);
    gq = adv(gq, w);
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_mq = 0; m_we = 0; m_ec = 0; m_bc = 0;
    m_wev = 0; m_sat = 0;
    m_hist.delete();
  endtask
  task automatic model(bit v, logic [W-1:0] d, int md, bit clr);
    bq_t z;
    logic [W-1:0] p;
    int e = 0;
    bit cnt = 0;
    if (md != m_mq) begin m_state = 0; m_good = 0; m_bad = 0; end
    m_mq = md;
    if (v) begin
      if (m_state == 0) begin
        m_hist = adv(z, d); m_good = 0; m_state = 1;
      end else if (m_state == 1) begin
        if (d === predict(m_hist, md)) begin
          m_hist = adv(m_hist, d);
          m_good++;
          if (m_good == 4) begin m_state = 2; m_bad = 0; end
        end else begin
          m_hist = adv(z, d); m_good = 0;
        end
      end else begin
        p = predict(m_hist, md);
        e = $countones(d ^ p);
        m_hist = adv(m_hist, p);
        cnt = 1;
        m_bad = e > W / 4 ? m_bad + 1 : 0;
        if (m_bad == 4) m_state = 0;
      end
    end
    m_wev = cnt;
    m_we = e;
    if (clr) begin
      m_ec = 0; m_bc = 0; m_sat = 0;
    end else if (cnt) begin
      m_ec = m_ec + e > EMAX ? EMAX : m_ec + e;
      m_bc = m_bc + W > BMAX ? BMAX : m_bc + W;
      if (m_ec == EMAX || m_bc == BMAX) m_sat = 1;
    end
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic cmp_all();
    chk("locked", locked, 64'(m_state == 2));
    chk("word_err_valid", word_err_valid, m_wev);
    if (m_wev) chk("word_err", word_err, m_we);
    chk("err_count", err_count, m_ec);
    chk("bit_count", bit_count, m_bc);
    chk("err_sat", err_sat, m_sat);
  endtask

  task automatic step(bit v, logic [W-1:0] d, bit clr);
    @(negedge clk);
    data_valid = v; data = d; clear = clr;
    @(posedge clk);
    model(v, d, mode, clr);
    #1 cmp_all();
  endtask
  task automatic send(logic [W-1:0] flip, bit clr = 0);
    logic [W-1:0] w;
    gen(w);
    step(1, w ^ flip, clr);
  endtask
  task automatic clean(int n);
    for (int i = 0; i < n; i++) send('0);
  endtask

  initial begin
    logic [W-1:0] flip;
    model_reset();
    #2 cmp_all();
    chk("rst_word_err", word_err, 0);
    @(posedge clk); #1 reset = 1;
    // PRBS31 clean lock and bit counting
    mode = 3; gen_seed(3);
    for (int i = 0; i < 10; i++) begin
      send('0);
      if (i == 3) chk("t1_not_yet_locked", locked, 0);
      if (i == 4) chk("t1_locked", locked, 1);
    end
    chk("t1_bit_count", bit_count, 160);
    chk("t1_err_count", err_count, 0);
    // PRBS7 three-bit error, no propagation; clear beats a counted word
    mode = 0; gen_seed(0); clean(5);
    chk("t2_locked", locked, 1);
    send('0, 1);
    chk("t2_clear_bits", bit_count, 0);
    flip = '0;
    while ($countones(flip) != 3) flip |= W'(1) << $urandom_range(0, W - 1);
    send(flip);
    chk("t2_word_err", word_err, 3);
    chk("t2_err_count", err_count, 3);
    chk("t2_still_locked", locked, 1);
    send('0);
    chk("t2_next_word_err", word_err, 0);
    chk("t2_next_valid", word_err_valid, 1);
    // PRBS15 loss of lock after four inverted words, then relock
    mode = 1; gen_seed(1); clean(5);
    step(0, $urandom, 1);
    for (int i = 0; i < 4; i++) begin
      send('1);
      if (i == 2) chk("t3_locked_w2", locked, 1);
    end
    chk("t3_lost", locked, 0);
    chk("t3_err_count", err_count, 128);
    clean(4);
    chk("t3_not_relocked", locked, 0);
    clean(1);
    chk("t3_relocked", locked, 1);
    // Error counter saturation, clear, then bit counter saturation
    send('0, 1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) send('1);
      send('0);
    end
    chk("t4_err_sat_cnt", err_count, EMAX);
    chk("t4_err_sat", err_sat, 1);
    chk("t4_locked", locked, 1);
    step(0, $urandom, 1);
    chk("t4_clr_err", err_count, 0);
    chk("t4_clr_bits", bit_count, 0);
    chk("t4_clr_sat", err_sat, 0);
    clean(130);
    chk("t4_bit_sat_cnt", bit_count, BMAX);
    chk("t4_bit_sat", err_sat, 1);
    // PRBS23 locked, switch to PRBS31 with a valid word in the same cycle
    mode = 2; gen_seed(2); clean(5);
    send('0, 1);
    clean(3);
    chk("t5_bits_before", bit_count, 96);
    mode = 3; gen_seed(3);
    send('0);
    chk("t5_dropped", locked, 0);
    chk("t5_bits_kept", bit_count, 96);
    clean(3);
    chk("t5_not_relocked", locked, 0);
    clean(1);
    chk("t5_relocked", locked, 1);
    // Async reset while locked with gaps, then relock across idle cycles
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) step(0, $urandom, 0);
      send('0);
    end
    data_valid = 0;
    #2 reset = 0;
    #1 model_reset();
    cmp_all();
    chk("t6_rst_word_err", word_err, 0);
    chk("t6_rst_locked", locked, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    gen_seed(3);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) step(0, $urandom, 0);
      send('0);
      if (i == 3) chk("t6_not_yet", locked, 0);
    end
    chk("t6_relocked", locked, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
